// File: rtl/text_row_sched.sv
// Scanline scheduler and content controller for the VGA text overlay: picks the text row that owns
// the glyph renderer and holds double-buffered label/value data, committed only at frame boundaries.
// Optional: define TEXT_ROW_SCHED_BLINK_EN to blank value_out during the upper half of a 64-frame cycle.
module text_row_sched #(
  parameter int ROW0_Y  = 200,
  parameter int ROW1_Y  = 250,
  parameter int GLYPH_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        newline,
  input  logic        newframe,
  input  logic [9:0]  y,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic        upd_sel,
  input  logic [31:0] upd_line,
  input  logic [7:0]  upd_value,
  output logic [1:0]  region,
  output logic [2:0]  rownum,
  output logic [31:0] line_out,
  output logic [7:0]  value_out
);

  typedef enum logic [1:0] {IDLE, ROW0, ROW1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  rownum_d;
  logic        blank;

  logic [31:0] live_line [2];
  logic [7:0]  live_value[2];
  logic [31:0] shd_line  [2];
  logic [7:0]  shd_value [2];
  logic [1:0]  pend;
  logic        xfer;

  assign upd_ready = !pend[upd_sel];
  assign xfer      = upd_valid && upd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rownum  <= '0;
    end else begin
      state_q <= state_d;
      rownum  <= rownum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rownum_d = rownum;
    if (newframe) begin
      state_d  = IDLE;
      rownum_d = '0;
    end else if (newline) begin
      case (state_q)
        IDLE: begin
          if (y == 10'(ROW0_Y)) begin
            state_d  = ROW0;
            rownum_d = '0;
          end else if (y == 10'(ROW1_Y)) begin
            state_d  = ROW1;
            rownum_d = '0;
          end
        end
        ROW0, ROW1: begin
          // Start matches are ignored here: the active row always runs to completion.
          if (rownum == 3'(GLYPH_H - 1)) begin
            state_d  = IDLE;
            rownum_d = '0;
          end else begin
            rownum_d = rownum + 3'd1;
          end
        end
        default: begin
          state_d  = IDLE;
          rownum_d = '0;
        end
      endcase
    end
  end

`ifdef TEXT_ROW_SCHED_BLINK_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           frame_cnt <= '0;
    else if (newframe) frame_cnt <= frame_cnt + 6'd1;
  end

  assign blank = frame_cnt[5];
`else
  assign blank = 1'b0;
`endif

  // Outputs are registered from the next state so they follow the strobe by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      region    <= '0;
      line_out  <= '0;
      value_out <= '0;
    end else begin
      case (state_d)
        ROW0: begin
          region    <= 2'b01;
          line_out  <= live_line[0];
          value_out <= blank ? 8'hFF : live_value[0];
        end
        ROW1: begin
          region    <= 2'b10;
          line_out  <= live_line[1];
          value_out <= blank ? 8'hFF : live_value[1];
        end
        default: begin
          region    <= '0;
          line_out  <= '0;
          value_out <= '0;
        end
      endcase
    end
  end

  // A transfer needs pend clear for its row, so it never collides with that row's commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        live_line[i]  <= '0;
        live_value[i] <= '0;
        shd_line[i]   <= '0;
        shd_value[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (newframe && pend[i]) begin
          live_line[i]  <= shd_line[i];
          live_value[i] <= shd_value[i];
          pend[i]       <= 1'b0;
        end
        if (xfer && (upd_sel == 1'(i))) begin
          shd_line[i]  <= upd_line;
          shd_value[i] <= upd_value;
          pend[i]      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_row_sched.sv
// Directed self-checking bench for text_row_sched; expectations follow the row/commit behaviour,
// with the blink expectation selected by TEXT_ROW_SCHED_BLINK_EN.
module tb_text_row_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        newline, newframe;
  logic [9:0]  y;
  logic        upd_valid, upd_ready, upd_sel;
  logic [31:0] upd_line;
  logic [7:0]  upd_value;
  logic [1:0]  region;
  logic [2:0]  rownum;
  logic [31:0] line_out;
  logic [7:0]  value_out;

  int checks = 0;
  int errors = 0;

  text_row_sched #(.ROW0_Y(200), .ROW1_Y(250), .GLYPH_H(8)) dut (
    .clk(clk), .rst(rst), .newline(newline), .newframe(newframe), .y(y),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_sel(upd_sel),
    .upd_line(upd_line), .upd_value(upd_value), .region(region),
    .rownum(rownum), .line_out(line_out), .value_out(value_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One strobe cycle: inputs driven at negedge, outputs sampled 1 time unit after the edge.
  task automatic strobe(input logic [9:0] yv, input logic nl, input logic nf);
    @(negedge clk);
    newline = nl; newframe = nf; y = yv;
    @(posedge clk); #1;
    newline = 1'b0; newframe = 1'b0;
  endtask

  task automatic line(input logic [9:0] yv);
    strobe(yv, 1'b1, 1'b0);
  endtask

  task automatic frame();
    strobe(10'd0, 1'b0, 1'b1);
  endtask

  task automatic update(input logic sel, input logic [31:0] l, input logic [7:0] v, input logic nf);
    @(negedge clk);
    upd_valid = 1'b1; upd_sel = sel; upd_line = l; upd_value = v; newframe = nf;
    @(posedge clk); #1;
    upd_valid = 1'b0; newframe = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    newline = 0; newframe = 0; y = '0; upd_valid = 0; upd_sel = 0;
    upd_line = '0; upd_value = '0;
    do_reset();

    // Reset state
    check("rst_region", 32'(region), 32'd0);
    check("rst_rownum", 32'(rownum), 32'd0);
    check("rst_line", line_out, 32'd0);
    check("rst_value", 32'(value_out), 32'd0);
    check("rst_ready0", 32'(upd_ready), 32'd1);
    upd_sel = 1'b1; #1;
    check("rst_ready1", 32'(upd_ready), 32'd1);

    // Row 0 window: y=199..208
    for (int yy = 199; yy <= 208; yy++) begin
      line(10'(yy));
      check($sformatf("win_region_y%0d", yy), 32'(region),
            (yy >= 200 && yy <= 207) ? 32'd1 : 32'd0);
      check($sformatf("win_rownum_y%0d", yy), 32'(rownum),
            (yy >= 200 && yy <= 207) ? 32'(yy - 200) : 32'd0);
    end

    // Load row 1 and show it
    update(1'b1, 32'h76543210, 8'h42, 1'b0);
    check("r1_ready_pend", 32'(upd_ready), 32'd0);
    frame();
    check("r1_ready_commit", 32'(upd_ready), 32'd1);
    line(10'd250);
    check("r1_region", 32'(region), 32'd2);
    check("r1_line", line_out, 32'h76543210);
    check("r1_value", 32'(value_out), 32'h42);
    // Start match for row 0 inside row 1 is ignored
    for (int yy = 251; yy <= 257; yy++) line(10'(yy));
    check("r1_last_rownum", 32'(rownum), 32'd7);
    line(10'd200);
    check("r1_end_region", 32'(region), 32'd0);

    // Row 0 mid-frame update stays hidden until newframe
    update(1'b0, 32'hAAAA0000, 8'h11, 1'b0);
    frame();
    line(10'd200);
    check("r0_old_value", 32'(value_out), 32'h11);
    check("r0_old_line", line_out, 32'hAAAA0000);
    update(1'b0, 32'hBBBB1111, 8'h5A, 1'b0);
    check("r0_ready_pend", 32'(upd_ready), 32'd0);
    upd_sel = 1'b1; #1;
    check("r1_ready_free", 32'(upd_ready), 32'd1);
    upd_sel = 1'b0;
    for (int yy = 201; yy <= 207; yy++) line(10'(yy));
    check("r0_value_held", 32'(value_out), 32'h11);
    frame();
    check("r0_ready_after", 32'(upd_ready), 32'd1);
    line(10'd200);
    check("r0_new_value", 32'(value_out), 32'h5A);
    check("r0_new_line", line_out, 32'hBBBB1111);

    // Update accepted in the newframe cycle waits one more frame
    update(1'b0, 32'hCCCC2222, 8'h77, 1'b1);
    check("same_nf_region", 32'(region), 32'd0);
    check("same_nf_ready", 32'(upd_ready), 32'd0);
    line(10'd200);
    check("same_nf_old", 32'(value_out), 32'h5A);
    frame();
    line(10'd200);
    check("same_nf_commit", 32'(value_out), 32'h77);
    check("same_nf_line", line_out, 32'hCCCC2222);

    // newframe beats newline at rownum 3
    frame();
    line(10'd200); line(10'd201); line(10'd202); line(10'd203);
    check("nf_pre_rownum", 32'(rownum), 32'd3);
    strobe(10'd204, 1'b1, 1'b1);
    check("nf_win_region", 32'(region), 32'd0);
    check("nf_win_rownum", 32'(rownum), 32'd0);
    check("nf_win_line", line_out, 32'd0);
    line(10'd205);
    check("nf_stay_idle", 32'(region), 32'd0);

    // Asynchronous reset mid-row drops a pending update
    line(10'd200);
    update(1'b1, 32'hDEADBEEF, 8'h99, 1'b0);
    #2 rst = 1'b1; #1;
    check("arst_region", 32'(region), 32'd0);
    check("arst_value", 32'(value_out), 32'd0);
    check("arst_ready", 32'(upd_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // 64-frame blink cycle; frame counter is 1 after the committing frame
    update(1'b0, 32'h01234567, 8'h3C, 1'b0);
    frame();
    for (int i = 0; i < 64; i++) begin
      int c;
      logic [7:0] exp_v;
      c = (1 + i) % 64;
`ifdef TEXT_ROW_SCHED_BLINK_EN
      exp_v = (c >= 32) ? 8'hFF : 8'h3C;
`else
      exp_v = 8'h3C;
`endif
      line(10'd200);
      check($sformatf("blink_f%0d", c), 32'(value_out), 32'(exp_v));
      if (i == 40) check("blink_line", line_out, 32'h01234567);
      frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
